// File: rtl/baud_gen_frac.sv
// baud_gen_frac -- fractional-N baud rate generator.
//
// Produces a registered one-cycle oversample tick (baud_tick_R) every
// act_int + act_frac/2^FRAC_W clocks on average, and a registered one-cycle
// bit tick (baud_tick_T) on every OSR-th oversample tick.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   enable       run the generator; low clears counters and phase
//   div_int      integer clocks per oversample tick (0 halts the generator)
//   div_frac     fractional clocks per oversample tick, units of 1/2^FRAC_W
//   div_load     one-cycle strobe capturing div_int/div_frac into the shadow
//   resync       one-cycle strobe restarting the phase (RX start-bit align)
//   baud_tick_R  registered oversample tick
//   baud_tick_T  registered bit tick, once per OSR baud_tick_R

module baud_gen_frac #(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OSR          = 16,
  parameter int DEFAULT_INT  = 2,
  parameter int DEFAULT_FRAC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              baud_tick_R,
  output logic              baud_tick_T
);

  localparam int OS_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);

  logic [DIV_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;
  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W:0]    cnt;
  logic [FRAC_W-1:0] acc;
  logic              extra;
  logic [OS_W-1:0]   os_cnt;

  logic [DIV_W:0]    period_m1;
  logic [FRAC_W:0]   acc_sum;
  logic              run;
  logic              wrap;

  // Period is act_int + extra, which can reach 2^DIV_W, hence the extra
  // bit on cnt and period_m1.
  always_comb begin
    period_m1 = {1'b0, act_int} + {{DIV_W{1'b0}}, extra} - (DIV_W+1)'(1);
    acc_sum   = {1'b0, acc} + {1'b0, act_frac};
    run       = enable && !resync && (act_int != '0);
    wrap      = run && (cnt == period_m1);
  end

  // Shadow divisor: captured on any strobe, independent of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_int  <= DIV_W'(DEFAULT_INT);
      sh_frac <= FRAC_W'(DEFAULT_FRAC);
    end else if (div_load) begin
      sh_int  <= div_int;
      sh_frac <= div_frac;
    end
  end

  // Active divisor loads from the shadow's pre-edge value, so a strobe
  // coincident with a wrap only takes effect at the following wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_int     <= DIV_W'(DEFAULT_INT);
      act_frac    <= FRAC_W'(DEFAULT_FRAC);
      cnt         <= '0;
      acc         <= '0;
      extra       <= 1'b0;
      os_cnt      <= '0;
      baud_tick_R <= 1'b0;
      baud_tick_T <= 1'b0;
    end else if (!run) begin
      // Disabled, resync, or halted (act_int == 0): drop phase, track shadow.
      act_int     <= sh_int;
      act_frac    <= sh_frac;
      cnt         <= '0;
      acc         <= '0;
      extra       <= 1'b0;
      os_cnt      <= '0;
      baud_tick_R <= 1'b0;
      baud_tick_T <= 1'b0;
    end else if (wrap) begin
      act_int     <= sh_int;
      act_frac    <= sh_frac;
      cnt         <= '0;
      acc         <= acc_sum[FRAC_W-1:0];
      extra       <= acc_sum[FRAC_W];
      os_cnt      <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
      baud_tick_R <= 1'b1;
      baud_tick_T <= (os_cnt == OS_LAST);
    end else begin
      cnt         <= cnt + (DIV_W+1)'(1);
      baud_tick_R <= 1'b0;
      baud_tick_T <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: expected tick maps are built from
// the divisor arithmetic, queued per clock edge, and popped/compared as the
// DUT produces its registered ticks.

module tb_baud_gen_frac;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;
  localparam int MAXE   = 256;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              resync;
  logic              baud_tick_R;
  logic              baud_tick_T;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;
  int os_model = 0;

  bit rmap [1:MAXE];
  bit tmap [1:MAXE];
  bit exp_r[$];
  bit exp_t[$];

  baud_gen_frac #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR),
    .DEFAULT_INT(2), .DEFAULT_FRAC(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .resync(resync), .baud_tick_R(baud_tick_R), .baud_tick_T(baud_tick_T)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_map();
    for (int i = 1; i <= MAXE; i++) begin
      rmap[i] = 1'b0;
      tmap[i] = 1'b0;
    end
    os_model = 0;
  endtask

  // Oversample tick at edge e; every OSR-th one since the last restart is a bit tick.
  task automatic add_tick(input int e);
    if (e >= 1 && e <= MAXE) begin
      rmap[e] = 1'b1;
      os_model++;
      if (os_model == OSR) begin
        tmap[e]  = 1'b1;
        os_model = 0;
      end
    end
  endtask

  // 2.5-clock divisor from a fresh start: first tick at 2, then 2,3,2,3,...
  task automatic add_default(input int last);
    int e;
    int k;
    e = 2;
    k = 0;
    while (e <= last) begin
      add_tick(e);
      e += (k % 2 == 0) ? 2 : 3;
      k++;
    end
  endtask

  task automatic push_map(input int last);
    for (int i = 1; i <= last; i++) begin
      exp_r.push_back(rmap[i]);
      exp_t.push_back(tmap[i]);
    end
  endtask

  task automatic push_zero(input int n);
    for (int i = 0; i < n; i++) begin
      exp_r.push_back(1'b0);
      exp_t.push_back(1'b0);
    end
  endtask

  task automatic check_now(input string tag, input logic er, input logic et);
    checks++;
    assert (baud_tick_R === er) else begin
      failures++;
      $error("FAIL %s tick_R: got %b expected %b", tag, baud_tick_R, er);
    end
    checks++;
    assert (baud_tick_T === et) else begin
      failures++;
      $error("FAIL %s tick_T: got %b expected %b", tag, baud_tick_T, et);
    end
  endtask

  task automatic step(input int n, input string tag);
    bit er;
    bit et;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_no++;
      if (exp_r.size() == 0 || exp_t.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s edge %0d: scoreboard empty, got R=%b T=%b expected an entry",
               tag, edge_no, baud_tick_R, baud_tick_T);
      end else begin
        er = exp_r.pop_front();
        et = exp_t.pop_front();
        checks++;
        assert (baud_tick_R === er) else begin
          failures++;
          $error("FAIL %s tick_R edge %0d: got %b expected %b", tag, edge_no, baud_tick_R, er);
        end
        checks++;
        assert (baud_tick_T === et) else begin
          failures++;
          $error("FAIL %s tick_T edge %0d: got %b expected %b", tag, edge_no, baud_tick_T, et);
        end
      end
    end
  endtask

  // Reset held across one edge, released just after it; next edge is edge 1.
  task automatic start_scn(input logic en, input string tag);
    reset    = 1'b0;
    enable   = en;
    div_load = 1'b0;
    resync   = 1'b0;
    div_int  = '0;
    div_frac = '0;
    exp_r.delete();
    exp_t.delete();
    @(posedge clk);
    #1;
    check_now(tag, 1'b0, 1'b0);
    reset   = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    // Defaults from reset release: intervals 2,2,3,2,3..., bit tick every 40.
    start_scn(1'b1, "rst_dflt");
    clear_map();
    add_default(90);
    push_map(90);
    step(90, "dflt");

    // Mid-period load of 5.0: current period finishes, then every 5 clocks.
    start_scn(1'b1, "rst_load");
    clear_map();
    add_tick(2); add_tick(4); add_tick(7);
    for (int e = 12; e <= 160; e += 5) add_tick(e);
    push_map(160);
    step(4, "load_mid");
    div_int = 16'd5; div_frac = 4'd0; div_load = 1'b1;
    step(1, "load_mid");
    div_load = 1'b0;
    step(155, "load_mid");

    // Load coincident with the wrap at edge 4: old divisor (with extra) once more.
    start_scn(1'b1, "rst_coinc");
    clear_map();
    add_tick(2); add_tick(4); add_tick(7);
    for (int e = 12; e <= 160; e += 5) add_tick(e);
    push_map(160);
    step(3, "load_wrap");
    div_int = 16'd5; div_frac = 4'd0; div_load = 1'b1;
    step(1, "load_wrap");
    div_load = 1'b0;
    step(156, "load_wrap");

    // Divisor 4.0, resync with cnt==2 at edge 11: no tick at 12, next at 15.
    start_scn(1'b0, "rst_resync");
    push_zero(2);
    div_int = 16'd4; div_frac = 4'd0; div_load = 1'b1;
    step(1, "resync_setup");
    div_load = 1'b0;
    step(1, "resync_setup");
    enable  = 1'b1;
    edge_no = 0;
    clear_map();
    add_tick(4); add_tick(8);
    os_model = 0;
    for (int e = 15; e <= 80; e += 4) add_tick(e);
    push_map(80);
    step(10, "resync");
    resync = 1'b1;
    step(1, "resync");
    resync = 1'b0;
    step(69, "resync");

    // Halt with div_int=0, then div_int=1.0: tick_R constantly high.
    start_scn(1'b1, "rst_halt");
    clear_map();
    add_tick(2); add_tick(4); add_tick(7);
    os_model = 0;
    for (int e = 15; e <= 60; e++) add_tick(e);
    push_map(60);
    step(4, "halt");
    div_int = 16'd0; div_frac = 4'd0; div_load = 1'b1;
    step(1, "halt");
    div_load = 1'b0;
    step(7, "halt");
    div_int = 16'd1; div_frac = 4'd0; div_load = 1'b1;
    step(1, "div1");
    div_load = 1'b0;
    step(47, "div1");

    // Divisor 7.0, async reset right after the edge where both ticks are high.
    start_scn(1'b0, "rst_async");
    push_zero(2);
    div_int = 16'd7; div_frac = 4'd0; div_load = 1'b1;
    step(1, "div7_setup");
    div_load = 1'b0;
    step(1, "div7_setup");
    enable  = 1'b1;
    edge_no = 0;
    clear_map();
    for (int e = 7; e <= 112; e += 7) add_tick(e);
    push_map(112);
    step(112, "div7");
    #1;
    reset = 1'b0;
    #1;
    check_now("async_rst", 1'b0, 1'b0);
    #2;
    reset   = 1'b1;
    edge_no = 0;
    clear_map();
    add_default(45);
    push_map(45);
    step(45, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
